// File: rtl/key_sched_if.sv
// Key-schedule port bundle: key load, completion status and round-key read channel.
// The master drives the key and read requests; the slave is the key_sched block.
interface key_sched_if;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         keys_valid;
    logic         done;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_valid;
    logic [127:0] rd_key;

    modport master (
        output key_valid, key_in, rd_en, rd_round,
        input  key_ready, keys_valid, done, rd_valid, rd_key
    );

    modport slave (
        input  key_valid, key_in, rd_en, rd_round,
        output key_ready, keys_valid, done, rd_valid, rd_key
    );
endinterface

// File: rtl/key_sched.sv
// AES-128 key expansion: one round key per cycle into an 11-entry store, plus a
// registered read port. key_gen computes a single expansion round combinationally.
module key_gen (
    input  logic [3:0]   round,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);
    // Row-major S-box; byte x sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        sub_byte = SBOX[{~b, 3'b000} +: 8];
    endfunction

    logic [31:0] w0, w1, w2, w3, rot, temp;
    logic [7:0]  rcon;

    always_comb begin
        unique case (round)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        {w0, w1, w2, w3} = key_in;
        rot  = {w3[23:0], w3[31:24]};
        temp = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
                sub_byte(rot[15:8]), sub_byte(rot[7:0])} ^ {rcon, 24'h0};
        key_out[127:96] = w0 ^ temp;
        key_out[95:64]  = w0 ^ temp ^ w1;
        key_out[63:32]  = w0 ^ temp ^ w1 ^ w2;
        key_out[31:0]   = w0 ^ temp ^ w1 ^ w2 ^ w3;
    end
endmodule

module key_sched #(
    parameter int unsigned NR = 10
) (
    input logic        clk,
    input logic        rst_n,
    key_sched_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic [127:0] rk [0:NR];
    logic         key_ready_q;
    logic         keys_valid_q;
    logic         done_q;
    logic         rd_valid_q;
    logic [127:0] rd_key_q;
    logic [127:0] kg_key;
    logic [127:0] kg_out;

    always_comb begin
        kg_key = '0;
        if (cnt_q <= 4'(NR - 1)) begin
            kg_key = rk[cnt_q];
        end
    end

    key_gen u_key_gen (
        .round   (cnt_q),
        .key_in  (kg_key),
        .key_out (kg_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            key_ready_q  <= 1'b1;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_key_q     <= '0;
            for (int i = 0; i <= int'(NR); i++) begin
                rk[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // Read port samples pre-edge store contents, so a same-edge reload is harmless.
            if (bus.rd_en) begin
                rd_valid_q <= keys_valid_q;
                if (keys_valid_q && bus.rd_round <= 4'(NR)) begin
                    rd_key_q <= rk[bus.rd_round];
                end else begin
                    rd_key_q <= '0;
                end
            end else begin
                rd_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle, StReady: begin
                    if (bus.key_valid) begin
                        rk[0]        <= bus.key_in;
                        cnt_q        <= '0;
                        keys_valid_q <= 1'b0;
                        key_ready_q  <= 1'b0;
                        state_q      <= StExpand;
                    end
                end
                StExpand: begin
                    rk[cnt_q + 4'd1] <= kg_out;
                    cnt_q            <= cnt_q + 4'd1;
                    if (cnt_q == 4'(NR - 1)) begin
                        state_q      <= StReady;
                        keys_valid_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                        done_q       <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.key_ready  = key_ready_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.done       = done_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_key     = rd_key_q;
endmodule

// File: tb/tb_key_sched.sv
// Directed bench for key_sched: FIPS-197 expansion, read sweep, busy rejection,
// reload with concurrent read, and reset during expansion.
module tb_key_sched;
    logic clk;
    logic rst_n;

    key_sched_if bus ();

    key_sched #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [127:0] k;
    } exp_t;

    exp_t         sb [$];
    int           total;
    int           bad;
    logic         prev_done;
    logic [127:0] last_k;

    localparam logic [127:0] K1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive the read request, queue its expected result, compare after the edge.
    task automatic tick(input logic en, input logic [3:0] rnd, input logic ev,
                        input logic [127:0] ek);
        exp_t e;
        bus.rd_en    = en;
        bus.rd_round = rnd;
        if (!rst_n) begin
            e.v = 1'b0;
            e.k = '0;
        end else if (!en) begin
            e.v = 1'b0;
            e.k = last_k;
        end else begin
            e.v = ev;
            e.k = ek;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e      = sb.pop_front();
        last_k = e.k;
        check("rd_valid", {127'b0, bus.rd_valid}, {127'b0, e.v});
        check("rd_key", bus.rd_key, e.k);
        check("done_single", {127'b0, bus.done & prev_done}, 128'b0);
        prev_done = bus.done;
    endtask

    task automatic idle();
        tick(1'b0, 4'd0, 1'b0, '0);
    endtask

    // Wait up to 20 cycles for done; optionally read while busy and inject a key at cycle inj.
    task automatic expand(input logic rd, input int inj, output int n);
        n = 20;
        for (int i = 1; i <= 20; i++) begin
            bus.key_valid = (i == inj);
            if (i == inj) begin
                bus.key_in = KEY2;
                check("busy_key_ready", {127'b0, bus.key_ready}, 128'b0);
            end
            tick(rd, 4'd10, 1'b0, '0);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        bus.key_valid = 1'b0;
    endtask

    initial begin
        int n;
        total         = 0;
        bad           = 0;
        prev_done     = 1'b0;
        last_k        = '0;
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rd_en     = 1'b0;
        bus.rd_round  = '0;

        idle();
        idle();
        rst_n = 1'b1;
        check("rst_key_ready", {127'b0, bus.key_ready}, 128'd1);
        check("rst_keys_valid", {127'b0, bus.keys_valid}, 128'd0);
        check("rst_done", {127'b0, bus.done}, 128'd0);

        // FIPS-197 load, reading round 10 throughout the expansion
        bus.key_valid = 1'b1;
        bus.key_in    = K1[0];
        idle();
        bus.key_valid = 1'b0;
        check("exp_key_ready", {127'b0, bus.key_ready}, 128'd0);
        expand(1'b1, 0, n);
        check("done_latency", 128'(n), 128'd10);
        check("ready_keys_valid", {127'b0, bus.keys_valid}, 128'd1);
        check("ready_key_ready", {127'b0, bus.key_ready}, 128'd1);

        // Back-to-back sweep, out-of-range rounds, then a hold cycle
        for (int r = 0; r <= 10; r++) begin
            tick(1'b1, 4'(r), 1'b1, K1[r]);
        end
        tick(1'b1, 4'd11, 1'b1, '0);
        tick(1'b1, 4'd15, 1'b1, '0);
        tick(1'b1, 4'd10, 1'b1, K1[10]);
        idle();

        // Reload from READY; a second key on cycle 3 of EXPAND must be ignored
        bus.key_valid = 1'b1;
        bus.key_in    = K1[0];
        idle();
        bus.key_valid = 1'b0;
        expand(1'b0, 3, n);
        check("busy_latency", 128'(n), 128'd10);
        tick(1'b1, 4'd10, 1'b1, K1[10]);

        // Reload with a same-edge read of round 0
        bus.key_valid = 1'b1;
        bus.key_in    = KEY2;
        tick(1'b1, 4'd0, 1'b1, K1[0]);
        bus.key_valid = 1'b0;
        check("reload_keys_valid", {127'b0, bus.keys_valid}, 128'd0);
        expand(1'b0, 0, n);
        check("reload_latency", 128'(n), 128'd10);
        tick(1'b1, 4'd10, 1'b1, KEY2_R10);
        tick(1'b1, 4'd0, 1'b1, KEY2);

        // Reset on cycle 5 of EXPAND
        bus.key_valid = 1'b1;
        bus.key_in    = K1[0];
        idle();
        bus.key_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idle();
        end
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        check("mid_rst_keys_valid", {127'b0, bus.keys_valid}, 128'd0);
        check("mid_rst_key_ready", {127'b0, bus.key_ready}, 128'd1);
        for (int i = 0; i < 15; i++) begin
            idle();
            check("mid_rst_no_done", {127'b0, bus.done}, 128'd0);
        end
        tick(1'b1, 4'd10, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_sched.md
KEY_SCHED -- requirements
Module: key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES-128 round keys generated after the cipher key; fixed at 10 for this release.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port key_valid, input, 1: key_in holds a new cipher key to load.
REQ-005 SHALL have port key_in, input, 128: cipher key, word w0 in [127:96].
REQ-006 SHALL have port key_ready, output, 1: the block can accept a key this cycle.
REQ-007 SHALL have port keys_valid, output, 1: all 11 round keys are stored and readable.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when expansion completes.
REQ-009 SHALL have port rd_en, input, 1: round-key read request.
REQ-010 SHALL have port rd_round, input, 4: index of the round key to read, 0..10.
REQ-011 SHALL have port rd_valid, output, 1: rd_key holds read data.
REQ-012 SHALL have port rd_key, output, 128: round key read data.

Function
REQ-013 SHALL contain an 11-entry x 128-bit round-key store rk[0..10] and one instance of the team's key_gen single-round expansion block.
REQ-014 SHALL implement states IDLE, EXPAND and READY; key_ready is 1 in IDLE and READY and 0 in EXPAND.
REQ-015 SHALL accept a key on a cycle with key_valid=1 and key_ready=1: rk[0] <= key_in, counter cnt <= 0, keys_valid <= 0, state <= EXPAND.
REQ-016 In EXPAND, each cycle SHALL drive key_gen with round=cnt and key_in=rk[cnt], then write its output to rk[cnt+1] and increment cnt.
REQ-017 On the write of rk[10] (cnt=9), the block SHALL set state <= READY and keys_valid <= 1, and pulse done for exactly one cycle.
REQ-018 done and keys_valid SHALL first be high on the 10th cycle after the acceptance edge.
REQ-019 SHALL ignore key_valid while in EXPAND; no restart and no corruption of the expansion in progress.
REQ-020 A new key accepted in READY SHALL restart expansion per REQ-015; keys_valid drops on that edge.
REQ-021 Reads SHALL have a registered one-cycle latency: when rd_en=1 and keys_valid=1 on an edge, the next cycle shows rd_valid=1 and rd_key=rk[rd_round], using the values held before that edge.
REQ-022 A read with rd_round > 10 SHALL return rd_valid=1 and rd_key=0.
REQ-023 When rd_en=1 and keys_valid=0, the next cycle SHALL show rd_valid=0 and rd_key=0.
REQ-024 When rd_en=0, rd_valid SHALL be 0 on the next cycle, and rd_key SHALL hold its previous value.
REQ-025 A read and a new-key acceptance on the same edge SHALL both complete; the read returns the pre-edge contents.
REQ-026 done SHALL never be high for two consecutive cycles.

Reset
REQ-027 While rst_n=0 at a clock edge: state <= IDLE, cnt <= 0, all rk entries <= 0, keys_valid <= 0, done <= 0, rd_valid <= 0, rd_key <= 0; key_ready reads 1 in the cycle after.
REQ-028 Reset asserted mid-EXPAND SHALL abandon the expansion; no done pulse follows.
REQ-029 No output SHALL be X after the first reset edge.

Verification
REQ-030 FIPS-197 key: load key_in=2b7e151628aed2a6abf7158809cf4f3c -> done pulses 10 cycles later; then reading rd_round=1 gives a0fafe1788542cb123a339392a6c7605, and rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 Read sweep: after REQ-030, read rounds 0..10 back to back -> 11 consecutive rd_valid cycles; round 0 returns the cipher key; rd_round=11 and rd_round=15 return 0 with rd_valid=1.
REQ-032 Busy rejection: after REQ-030, apply key_valid=1 with key_in=000102030405060708090a0b0c0d0e0f on cycle 3 of EXPAND -> key ignored and the REQ-030 round-10 value is unchanged.
REQ-033 Reload in READY with simultaneous read: after REQ-030, load key 000102030405060708090a0b0c0d0e0f together with rd_en=1, rd_round=0 -> rd_key returns 2b7e1516...; after done, round 10 reads 13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 Reset mid-expansion: assert rst_n=0 for 1 cycle at cycle 5 of EXPAND -> keys_valid=0, no done pulse, key_ready=1, and a read of round 10 returns rd_valid=0, rd_key=0.
REQ-035 Read before ready: set rd_en=1 during EXPAND -> rd_valid=0 and rd_key=0 on every such cycle.
